// File: rtl/eth_rx_frame_buffer.sv
// Receive-side store-and-forward frame buffer: only frames that complete with
// tuser=0 and fit in the buffer are forwarded; everything else is dropped and counted.
module eth_rx_frame_buffer #(
   parameter int unsigned DEPTH_LOG2 = 9
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [63:0] in_axis_tdata,
   input  logic [7:0]  in_axis_tkeep,
   input  logic        in_axis_tlast,
   input  logic        in_axis_tuser,
   input  logic        in_axis_tvalid,
   output logic        in_axis_tready,
   output logic [63:0] out_axis_tdata,
   output logic [7:0]  out_axis_tkeep,
   output logic        out_axis_tlast,
   output logic        out_axis_tvalid,
   input  logic        out_axis_tready,
   output logic [31:0] frames_ok,
   output logic [31:0] frames_dropped
);

   localparam int unsigned PTR_W  = DEPTH_LOG2 + 1;
   localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
   localparam int unsigned BEAT_W = 73;

   typedef enum logic {
      WRITE   = 1'b0,
      DISCARD = 1'b1
   } wstate_t;

   logic [BEAT_W-1:0] mem [DEPTH];

   wstate_t          state, state_n;
   logic [PTR_W-1:0] wr_ptr, wr_ptr_n;
   logic [PTR_W-1:0] wr_commit, wr_commit_n;
   logic [PTR_W-1:0] rd_ptr;
   logic             mem_we;
   logic             ok_inc, drop_inc;
   logic             full;
   logic             load;

   // Occupancy includes the uncommitted frame; the same-edge read never frees space.
   assign full = (wr_ptr - rd_ptr) == PTR_W'(DEPTH);

   // Move the next committed beat into the output stage when it is empty or draining.
   assign load = (rd_ptr != wr_commit) && (!out_axis_tvalid || out_axis_tready);

   // Write-side next state: store, commit, or rewind to the last committed frame.
   always_comb begin
      state_n     = state;
      wr_ptr_n    = wr_ptr;
      wr_commit_n = wr_commit;
      mem_we      = 1'b0;
      ok_inc      = 1'b0;
      drop_inc    = 1'b0;
      if (in_axis_tvalid) begin
         case (state)
            WRITE: begin
               if (full) begin
                  wr_ptr_n = wr_commit;
                  drop_inc = 1'b1;
                  if (!in_axis_tlast) state_n = DISCARD;
               end else begin
                  mem_we = 1'b1;
                  if (in_axis_tlast && in_axis_tuser) begin
                     wr_ptr_n = wr_commit;
                     drop_inc = 1'b1;
                  end else begin
                     wr_ptr_n = wr_ptr + PTR_W'(1);
                     if (in_axis_tlast) begin
                        wr_commit_n = wr_ptr + PTR_W'(1);
                        ok_inc      = 1'b1;
                     end
                  end
               end
            end
            DISCARD: begin
               if (in_axis_tlast) state_n = WRITE;
            end
            default: state_n = WRITE;
         endcase
      end
   end

   // Beat storage; contents need no reset since pointers gate every read.
   always_ff @(posedge clock) begin
      if (mem_we) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {in_axis_tdata, in_axis_tkeep, in_axis_tlast};
   end

   // Write-side state, pointers and frame counters.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= WRITE;
         wr_ptr         <= '0;
         wr_commit      <= '0;
         frames_ok      <= '0;
         frames_dropped <= '0;
      end else begin
         state     <= state_n;
         wr_ptr    <= wr_ptr_n;
         wr_commit <= wr_commit_n;
         if (ok_inc)   frames_ok      <= frames_ok + 32'd1;
         if (drop_inc) frames_dropped <= frames_dropped + 32'd1;
      end
   end

   // Registered output stage and read pointer.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr          <= '0;
         out_axis_tvalid <= 1'b0;
         out_axis_tdata  <= '0;
         out_axis_tkeep  <= '0;
         out_axis_tlast  <= 1'b0;
      end else if (load) begin
         {out_axis_tdata, out_axis_tkeep, out_axis_tlast} <= mem[rd_ptr[DEPTH_LOG2-1:0]];
         out_axis_tvalid <= 1'b1;
         rd_ptr          <= rd_ptr + PTR_W'(1);
      end else if (out_axis_tready) begin
         out_axis_tvalid <= 1'b0;
      end
   end

   // The MAC is never back-pressured outside reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) in_axis_tready <= 1'b0;
      else       in_axis_tready <= 1'b1;
   end

endmodule
